// File: rtl/key_beep_pattern.sv
// Per-key sync + debounce feeding a retriggerable beep pattern player (key i -> i+1 beeps).
// Latency: flag CNT_MAX+2 edges after first low sample, beep one cycle after flag; no backpressure.
module key_beep_pattern #(
  parameter int KEY_NUM  = 4,
  parameter int CNT_MAX  = 999_999,
  parameter int BEEP_LEN = 24_999_999
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_flag,
  output logic               beep,
  output logic               busy
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int LW = (BEEP_LEN > 1) ? $clog2(BEEP_LEN) : 1;

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  logic [KEY_NUM-1:0] s1, s2;
  logic [CW-1:0]      cnt [KEY_NUM];
  state_t             state;
  logic [LW-1:0]      len_cnt;
  logic [2:0]         beeps_left;
  logic               hit;
  logic [2:0]         sel;
  logic               len_end;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  // Counter saturates at CNT_MAX so a held key flags exactly once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < KEY_NUM; i++) cnt[i] <= '0;
      key_flag <= '0;
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (s2[i]) begin
          cnt[i]      <= '0;
          key_flag[i] <= 1'b0;
        end else begin
          if (cnt[i] != CW'(CNT_MAX)) cnt[i] <= cnt[i] + 1'b1;
          key_flag[i] <= (cnt[i] == CW'(CNT_MAX - 1));
        end
      end
    end
  end

  // Descending scan so the lowest flagged index is the one left in sel.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (key_flag[i]) begin
        hit = 1'b1;
        sel = 3'(i);
      end
    end
  end

  assign len_end = (len_cnt == LW'(BEEP_LEN - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      len_cnt    <= '0;
      beeps_left <= '0;
      beep       <= 1'b0;
      busy       <= 1'b0;
    end else if (hit) begin
      state      <= ON;
      len_cnt    <= '0;
      beeps_left <= sel;
      beep       <= 1'b1;
      busy       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          beep <= 1'b0;
          busy <= 1'b0;
        end
        ON: begin
          if (len_end) begin
            state   <= OFF;
            len_cnt <= '0;
            beep    <= 1'b0;
          end else begin
            len_cnt <= len_cnt + 1'b1;
          end
        end
        OFF: begin
          if (len_end) begin
            len_cnt <= '0;
            if (beeps_left != 3'd0) begin
              state      <= ON;
              beeps_left <= beeps_left - 1'b1;
              beep       <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            len_cnt <= len_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          beep  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_beep_pattern.sv
// Bench for key_beep_pattern with CNT_MAX=100, BEEP_LEN=50: vector table of presses plus
// hand-timed bounce, retrigger and async-reset sequences.
module tb_key_beep_pattern;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic [3:0] key_flag;
  logic       beep, busy;

  int checks = 0;
  int errors = 0;

  key_beep_pattern #(.KEY_NUM(4), .CNT_MAX(100), .BEEP_LEN(50)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .key_in   (key_in),
    .key_flag (key_flag),
    .beep     (beep),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  // Pattern monitor, sampled on the falling edge.
  int         flag_cnt [4] = '{default: 0};
  int         beep_rises = 0;
  int         bad_on = 0;
  int         bad_off = 0;
  int         last_busy = 0;
  int         beep_run = 0;
  int         off_run = 0;
  int         busy_run = 0;
  logic [3:0] prev_flag = 4'h0;
  logic       prev_beep = 1'b0;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (key_flag[i] && !prev_flag[i]) flag_cnt[i]++;
    if (beep && !prev_beep) beep_rises++;
    if (beep) beep_run++;
    else if (prev_beep) begin
      if (beep_run != 50) bad_on++;
      beep_run = 0;
    end
    if (busy && !beep) off_run++;
    else if (off_run != 0) begin
      if (off_run != 50) bad_off++;
      off_run = 0;
    end
    if (busy) busy_run++;
    else if (prev_busy) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
    prev_flag = key_flag;
    prev_beep = beep;
    prev_busy = busy;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Press for 150 cycles; e0 is the first posedge after the drive, k counts edges from e0.
  task automatic do_press(input logic [3:0] press, input int idx, output int rise, output int fall);
    rise = 0;
    fall = 0;
    @(negedge clk);
    key_in = ~press;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk);
      #1;
      if (key_flag[idx] && rise == 0) rise = k;
      else if (!key_flag[idx] && rise != 0 && fall == 0) fall = k;
    end
    @(negedge clk);
    key_in = 4'hF;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] press;
    logic [3:0] exp_flags;
    int         exp_beeps;
    int         exp_busy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int rise, fall, lo, mism_b, mism_y, mism_f;
    int snap_f [4];
    int snap_r, snap_on, snap_off;
    logic exp_b, exp_y, exp_f;

    vecs[0] = '{4'b0001, 4'b0001, 1, 100};
    vecs[1] = '{4'b0100, 4'b0100, 3, 300};
    vecs[2] = '{4'b0010, 4'b0010, 2, 200};
    vecs[3] = '{4'b1000, 4'b1000, 4, 400};
    vecs[4] = '{4'b1010, 4'b1010, 2, 200};
    vecs[5] = '{4'b1111, 4'b1111, 1, 100};

    // Reset held 200 ns with keys idle, then released.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("reset_outputs", int'({key_flag, beep, busy}), 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_reset_outputs", int'({key_flag, beep, busy}), 0);
    end

    // Table of single and simultaneous presses.
    for (int v = 0; v < 6; v++) begin
      lo = 0;
      for (int i = 3; i >= 0; i--) if (vecs[v].press[i]) lo = i;
      for (int i = 0; i < 4; i++) snap_f[i] = flag_cnt[i];
      snap_r   = beep_rises;
      snap_on  = bad_on;
      snap_off = bad_off;
      do_press(vecs[v].press, lo, rise, fall);
      wait_idle($sformatf("v%0d_busy_timeout", v));
      check($sformatf("v%0d_flag_rise_edge", v), rise, 102);
      check($sformatf("v%0d_flag_fall_edge", v), fall, 103);
      for (int i = 0; i < 4; i++)
        check($sformatf("v%0d_flag_count_key%0d", v, i), flag_cnt[i] - snap_f[i],
              int'(vecs[v].exp_flags[i]));
      check($sformatf("v%0d_beep_count", v), beep_rises - snap_r, vecs[v].exp_beeps);
      check($sformatf("v%0d_busy_cycles", v), last_busy, vecs[v].exp_busy);
      check($sformatf("v%0d_bad_on_phases", v), bad_on - snap_on, 0);
      check($sformatf("v%0d_bad_off_phases", v), bad_off - snap_off, 0);
    end

    // Bounce on key 1: short low pulses (2..75 cycles) never flag.
    snap_f[1] = flag_cnt[1];
    snap_r    = beep_rises;
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      key_in = 4'b1101;
      repeat (2 + (p * 37) % 74) @(negedge clk);
      key_in = 4'hF;
      repeat (5) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce_no_flag", flag_cnt[1] - snap_f[1], 0);
    check("bounce_no_beep", beep_rises - snap_r, 0);
    snap_on  = bad_on;
    snap_off = bad_off;
    do_press(4'b0010, 1, rise, fall);
    wait_idle("bounce_busy_timeout");
    check("bounce_hold_flag", flag_cnt[1] - snap_f[1], 1);
    check("bounce_hold_beeps", beep_rises - snap_r, 2);
    check("bounce_hold_busy", last_busy, 200);
    check("bounce_hold_phases", (bad_on - snap_on) + (bad_off - snap_off), 0);

    // Retrigger: key 3 at e0=1, key 0 pressed during key 3's second beep (e0'=213).
    // Key 0's flag lands at edge 314, inside key 3's third ON phase (303..352).
    mism_b = 0;
    mism_y = 0;
    mism_f = 0;
    snap_r = beep_rises;
    @(negedge clk);
    key_in = 4'b0111;
    for (int e = 1; e <= 450; e++) begin
      @(posedge clk);
      #1;
      exp_b = (e >= 103 && e <= 152) || (e >= 203 && e <= 252) || (e >= 303 && e <= 364);
      exp_y = (e >= 103 && e <= 414);
      exp_f = (e == 314);
      if (beep !== exp_b) mism_b++;
      if (busy !== exp_y) mism_y++;
      if (key_flag[0] !== exp_f) mism_f++;
      if (e == 150) key_in = 4'hF;
      if (e == 212) key_in = 4'b1110;
      if (e == 400) key_in = 4'hF;
    end
    check("retrig_beep_bad_edges", mism_b, 0);
    check("retrig_busy_bad_edges", mism_y, 0);
    check("retrig_flag0_bad_edges", mism_f, 0);
    repeat (2) @(negedge clk);
    check("retrig_beep_count", beep_rises - snap_r, 3);

    // Async reset mid-ON with key 2 held; flag must wait a full debounce after release.
    @(negedge clk);
    key_in = 4'b1011;
    for (int e = 1; e <= 120; e++) @(posedge clk);
    #1;
    check("rst_pre_beep", int'(beep), 1);
    #4;
    rst_n = 1'b0;
    #1;
    check("rst_async_beep", int'(beep), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_flag", int'(key_flag), 0);
    for (int e = 121; e <= 125; e++) @(posedge clk);
    #5;
    rst_n = 1'b1;
    mism_b = 0;
    mism_f = 0;
    for (int e = 126; e <= 300; e++) begin
      @(posedge clk);
      #1;
      exp_f = (e == 227);
      exp_b = (e >= 228 && e <= 277);
      if (key_flag[2] !== exp_f) mism_f++;
      if (beep !== exp_b) mism_b++;
    end
    check("rst_rearm_flag_bad_edges", mism_f, 0);
    check("rst_rearm_beep_bad_edges", mism_b, 0);
    key_in = 4'hF;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
